// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Contents:
//   DefDataWidth / DefAddrWidth / DefResetPc : default parameter values
//   FS_RUN / FS_HALT                          : fetch FSM encodings (fstate debug output)
package instruction_fetch_pkg;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefResetPc   = 0;

  localparam logic [0:0] FS_RUN  = 1'b0;
  localparam logic [0:0] FS_HALT = 1'b1;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Two-entry FIFO of {pc, word} pairs that sits between the ROM read port and the
// instruction-register load.
// Ports:
//   clk_i, rst_ni              : clock, synchronous active-low reset
//   push_i, push_pc_i/word_i   : write a returned ROM word at the tail
//   pop_i                      : remove the head entry (ignored when empty)
//   flush_i                    : discard all entries; wins over push
//   head_pc_o, head_word_o     : head entry (zero after reset)
//   count_o                    : occupancy 0..2
module instruction_fetch_buffer #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [AddrWidth-1:0] push_pc_i,
  input  logic [DataWidth-1:0] push_word_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [AddrWidth-1:0] head_pc_o,
  output logic [DataWidth-1:0] head_word_o,
  output logic [1:0]           count_o
);

  logic [AddrWidth-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [DataWidth-1:0] wd0_q, wd0_d, wd1_q, wd1_d;
  logic [1:0]           count_q, count_d;
  logic                 pop_eff;
  logic [1:0]           wr_idx;

  assign pop_eff = pop_i && (count_q != 2'd0);

  always_comb begin
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    wd0_d   = wd0_q;
    wd1_d   = wd1_q;
    count_d = count_q;
    wr_idx  = count_q - {1'b0, pop_eff};
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      // Pop shifts entry 1 into the head; the push then lands in the first free slot.
      if (pop_eff) begin
        pc0_d = pc1_q;
        wd0_d = wd1_q;
      end
      if (push_i) begin
        if (wr_idx == 2'd0) begin
          pc0_d = push_pc_i;
          wd0_d = push_word_i;
        end else begin
          pc1_d = push_pc_i;
          wd1_d = push_word_i;
        end
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_eff};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc0_q   <= '0;
      pc1_q   <= '0;
      wd0_q   <= '0;
      wd1_q   <= '0;
      count_q <= 2'd0;
    end else begin
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
      wd0_q   <= wd0_d;
      wd1_q   <= wd1_d;
      count_q <= count_d;
    end
  end

  assign head_pc_o   = pc0_q;
  assign head_word_o = wd0_q;
  assign count_o     = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: walks the PC, reads the synchronous ROM (1-cycle latency) and hands words to
// the instruction-register load over a valid/ready handshake, via a 2-entry skid buffer.
// Ports:
//   clock, resetnot        : clock, synchronous active-low reset
//   rom_addr / rom_q       : ROM read address (= pc) and data returned the next cycle
//   instr, instr_pc        : head-of-buffer word and its address
//   instr_valid/ready      : handshake; a transfer pops the head and bumps fetch_count
//   redirect, redirect_pc  : flush and restart fetch at redirect_pc
//   halt                   : level; stops new ROM reads while buffered words drain
//   pc, fetch_count, fstate: next issue address, accepted count, FSM state (debug)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned RESET_PC   = DefResetPc
) (
  input  logic                  clock,
  input  logic                  resetnot,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           fetch_count,
  output logic                  fstate
);

  localparam logic [ADDR_WIDTH-1:0] PcOne   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PcReset = ADDR_WIDTH'(RESET_PC);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] infl_pc_q;
  logic                  infl_q;
  logic [0:0]            fstate_q, fstate_d;
  logic [15:0]           count_q, count_d;
  logic [1:0]            occ;
  logic [2:0]            used;
  logic                  transfer;
  logic                  issue;

  assign instr_valid = (occ != 2'd0);
  assign transfer    = instr_valid && instr_ready;

  // A transfer this cycle frees its slot at the same edge, so it returns a credit immediately;
  // without that, ready=1 streaming would bubble every other word.
  assign used  = 3'(occ) + 3'(infl_q) - 3'(transfer);
  assign issue = (fstate_q == FS_RUN) && !redirect && (used < 3'd2);

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_q + PcOne;
    end
    fstate_d = halt ? FS_HALT : FS_RUN;
    count_d  = count_q + 16'(transfer);
  end

  always_ff @(posedge clock) begin
    if (!resetnot) begin
      pc_q      <= PcReset;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      fstate_q  <= FS_RUN;
      count_q   <= 16'd0;
    end else begin
      pc_q      <= pc_d;
      infl_q    <= issue;
      // Only meaningful while infl_q is set: the address issued in the previous cycle.
      infl_pc_q <= pc_q;
      fstate_q  <= fstate_d;
      count_q   <= count_d;
    end
  end

  instruction_fetch_buffer #(
    .DataWidth(DATA_WIDTH),
    .AddrWidth(ADDR_WIDTH)
  ) u_buffer (
    .clk_i      (clock),
    .rst_ni     (resetnot),
    .push_i     (infl_q),
    .push_pc_i  (infl_pc_q),
    .push_word_i(rom_q),
    .pop_i      (transfer),
    .flush_i    (redirect),
    .head_pc_o  (instr_pc),
    .head_word_o(instr),
    .count_o    (occ)
  );

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign fetch_count = count_q;
  assign fstate      = fstate_q[0];

endmodule
